// File: rtl/ld_align_unit_if.sv
// Load-align unit bus bundle: request, memory-read and response channels.
// The "slave" view belongs to the load unit, the "master" view to whatever
// drives it (LSU request side, data memory and result consumer).
interface ld_align_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();
    // Request channel
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [2:0]            req_funct3;
    // Memory read channel
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;
    // Response channel
    logic                  resp_valid;
    logic                  resp_ready;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_err;

    modport slave (
        input  req_valid, req_addr, req_funct3,
        output req_ready,
        output mem_req_valid, mem_addr,
        input  mem_req_ready, mem_rvalid, mem_rdata,
        output resp_valid, resp_data, resp_err,
        input  resp_ready
    );

    modport master (
        output req_valid, req_addr, req_funct3,
        input  req_ready,
        input  mem_req_valid, mem_addr,
        output mem_req_ready, mem_rvalid, mem_rdata,
        input  resp_valid, resp_data, resp_err,
        output resp_ready
    );
endinterface

// File: rtl/ld_align_unit.sv
// Sequential load unit: takes one (address, funct3) load at a time, issues one
// or two word-aligned reads, merges the bytes in ascending address order,
// packs them big-endian (lowest address = most significant byte), extends to
// DATA_WIDTH and returns the result over a valid/ready response port.
module ld_align_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32,
    parameter bit MISALIGNED_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    ld_align_unit_if.slave  bus
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFW  = $clog2(BYTES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ0  = 3'd1,
        S_WAIT0 = 3'd2,
        S_REQ1  = 3'd3,
        S_WAIT1 = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    // Access size in bytes; the 2'b11 encoding covers ld (and illegal 111).
    function automatic logic [3:0] f3_size(input logic [2:0] f3);
        logic [3:0] sz;
        case (f3[1:0])
            2'b00:   sz = 4'd1;
            2'b01:   sz = 4'd2;
            2'b10:   sz = 4'd4;
            default: sz = 4'd8;
        endcase
        return sz;
    endfunction

    // lwu and ld exist only when the word is 64 bits wide.
    function automatic logic f3_legal(input logic [2:0] f3);
        logic ok;
        case (f3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
            3'b011, 3'b110:                         ok = (DATA_WIDTH == 64);
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Unsigned variants all have funct3[2] set.
    function automatic logic f3_signed(input logic [2:0] f3);
        return ~f3[2];
    endfunction

    state_t                  r_state;
    logic [OFFW-1:0]         r_off;
    logic [2:0]              r_funct3;
    logic [DATA_WIDTH-1:0]   r_beat0;
    logic                    r_mem_req_valid;
    logic [ADDR_WIDTH-1:0]   r_mem_addr;
    logic                    r_resp_valid;
    logic [DATA_WIDTH-1:0]   r_resp_data;
    logic                    r_resp_err;

    // Incoming-request decode
    logic [OFFW-1:0]         w_in_off;
    logic [3:0]              w_in_size;
    logic                    w_in_misal;
    logic                    w_in_bad;
    logic [ADDR_WIDTH-1:0]   w_in_base;

    // Decode of the registered access
    logic [3:0]              w_size;
    logic                    w_cross;

    // Data path
    logic [2*DATA_WIDTH-1:0] w_merge;
    logic [4:0]              w_idx;
    logic [DATA_WIDTH-1:0]   w_val;
    logic                    w_neg;
    logic [DATA_WIDTH-1:0]   w_res;

    assign w_in_off  = bus.req_addr[OFFW-1:0];
    assign w_in_size = f3_size(bus.req_funct3);
    assign w_in_base = {bus.req_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
    // Sizes are powers of two, so "off is a multiple of size" is a mask test.
    assign w_in_misal = ((5'(w_in_off) & (5'(w_in_size) - 5'd1)) != 5'd0);
    assign w_in_bad   = ~f3_legal(bus.req_funct3) | (w_in_misal & ~MISALIGNED_EN);

    assign w_size  = f3_size(r_funct3);
    assign w_cross = ((5'(r_off) + 5'(w_size)) > 5'(BYTES));

    // Two-word byte array {beat1, beat0}; a single-beat access has no beat1.
    always_comb begin
        if (r_state == S_WAIT1) begin
            w_merge = {bus.mem_rdata, r_beat0};
        end else begin
            w_merge = {{DATA_WIDTH{1'b0}}, bus.mem_rdata};
        end
    end

    // Pick bytes off..off+size-1 in address order, packing the first one highest.
    always_comb begin
        w_val = {DATA_WIDTH{1'b0}};
        w_idx = 5'd0;
        for (int i = 0; i < BYTES; i++) begin
            if (5'(i) < 5'(w_size)) begin
                w_idx = 5'(r_off) + 5'(i);
                w_val = {w_val[DATA_WIDTH-9:0], w_merge[{w_idx, 3'b000} +: 8]};
            end else begin
                w_val = w_val;
            end
        end
    end

    // Signed loads extend from bit 7 of the lowest-addressed byte.
    always_comb begin
        w_neg = f3_signed(r_funct3) & w_merge[{5'(r_off), 3'b111}];
        w_res = w_val;
        for (int j = 0; j < BYTES; j++) begin
            if (w_neg && (5'(j) >= 5'(w_size))) begin
                w_res[j*8 +: 8] = 8'hFF;
            end else begin
                w_res[j*8 +: 8] = w_val[j*8 +: 8];
            end
        end
    end

    // Control FSM with all bus-facing outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_off           <= {OFFW{1'b0}};
            r_funct3        <= 3'b000;
            r_beat0         <= {DATA_WIDTH{1'b0}};
            r_mem_req_valid <= 1'b0;
            r_mem_addr      <= {ADDR_WIDTH{1'b0}};
            r_resp_valid    <= 1'b0;
            r_resp_data     <= {DATA_WIDTH{1'b0}};
            r_resp_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_off    <= w_in_off;
                        r_funct3 <= bus.req_funct3;
                        if (w_in_bad) begin
                            // Errors answer straight away without touching memory.
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_data  <= {DATA_WIDTH{1'b0}};
                            r_resp_err   <= 1'b1;
                        end else begin
                            r_state         <= S_REQ0;
                            r_mem_req_valid <= 1'b1;
                            r_mem_addr      <= w_in_base;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_REQ0: begin
                    if (bus.mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= S_WAIT0;
                    end else begin
                        r_state <= S_REQ0;
                    end
                end
                S_WAIT0: begin
                    if (bus.mem_rvalid) begin
                        r_beat0 <= bus.mem_rdata;
                        if (w_cross) begin
                            r_state         <= S_REQ1;
                            r_mem_req_valid <= 1'b1;
                            r_mem_addr      <= r_mem_addr + ADDR_WIDTH'(BYTES);
                        end else begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_data  <= w_res;
                            r_resp_err   <= 1'b0;
                        end
                    end else begin
                        r_state <= S_WAIT0;
                    end
                end
                S_REQ1: begin
                    if (bus.mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= S_WAIT1;
                    end else begin
                        r_state <= S_REQ1;
                    end
                end
                S_WAIT1: begin
                    if (bus.mem_rvalid) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_data  <= w_res;
                        r_resp_err   <= 1'b0;
                    end else begin
                        r_state <= S_WAIT1;
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= S_IDLE;
                    end else begin
                        r_state <= S_RESP;
                    end
                end
                default: begin
                    r_state         <= S_IDLE;
                    r_mem_req_valid <= 1'b0;
                    r_resp_valid    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready     = (r_state == S_IDLE) & rst_n;
    assign bus.mem_req_valid = r_mem_req_valid;
    assign bus.mem_addr      = r_mem_addr;
    assign bus.resp_valid    = r_resp_valid;
    assign bus.resp_data     = r_resp_data;
    assign bus.resp_err      = r_resp_err;

endmodule

// File: tb/tb_ld_align_unit.sv
// Directed bench for ld_align_unit: two 32-bit units (misaligned split on/off)
// share one driver selected by sel, plus a 64-bit unit for the backpressure case.
module tb_ld_align_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    ld_align_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if_a ();
    ld_align_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) if_e ();
    ld_align_unit_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) if_w ();

    ld_align_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MISALIGNED_EN(1'b1))
        u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
    ld_align_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MISALIGNED_EN(1'b0))
        u_e (.clk(clk), .rst_n(rst_n), .bus(if_e.slave));
    ld_align_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .MISALIGNED_EN(1'b1))
        u_w (.clk(clk), .rst_n(rst_n), .bus(if_w.slave));

    // Shared 32-bit driver
    logic        sel;
    logic        req_valid;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic        mem_req_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_ready;

    assign if_a.req_valid     = req_valid & ~sel;
    assign if_e.req_valid     = req_valid & sel;
    assign if_a.req_addr      = req_addr;
    assign if_e.req_addr      = req_addr;
    assign if_a.req_funct3    = req_funct3;
    assign if_e.req_funct3    = req_funct3;
    assign if_a.mem_req_ready = mem_req_ready;
    assign if_e.mem_req_ready = mem_req_ready;
    assign if_a.mem_rvalid    = mem_rvalid;
    assign if_e.mem_rvalid    = mem_rvalid;
    assign if_a.mem_rdata     = mem_rdata;
    assign if_e.mem_rdata     = mem_rdata;
    assign if_a.resp_ready    = resp_ready;
    assign if_e.resp_ready    = resp_ready;

    logic        o_req_ready, o_mem_req_valid, o_resp_valid, o_resp_err;
    logic [31:0] o_mem_addr, o_resp_data;
    assign o_req_ready     = sel ? if_e.req_ready     : if_a.req_ready;
    assign o_mem_req_valid = sel ? if_e.mem_req_valid : if_a.mem_req_valid;
    assign o_mem_addr      = sel ? if_e.mem_addr      : if_a.mem_addr;
    assign o_resp_valid    = sel ? if_e.resp_valid    : if_a.resp_valid;
    assign o_resp_data     = sel ? if_e.resp_data     : if_a.resp_data;
    assign o_resp_err      = sel ? if_e.resp_err      : if_a.resp_err;

    // 64-bit driver
    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic [2:0]  w_req_funct3;
    logic        w_mem_req_ready;
    logic        w_mem_rvalid;
    logic [63:0] w_mem_rdata;
    logic        w_resp_ready;

    assign if_w.req_valid     = w_req_valid;
    assign if_w.req_addr      = w_req_addr;
    assign if_w.req_funct3    = w_req_funct3;
    assign if_w.mem_req_ready = w_mem_req_ready;
    assign if_w.mem_rvalid    = w_mem_rvalid;
    assign if_w.mem_rdata     = w_mem_rdata;
    assign if_w.resp_ready    = w_resp_ready;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One load on the selected 32-bit unit; memory grants at once and returns
    // data the cycle after each accepted read (b0 for the first, b1 for the second).
    task automatic do_load32(input string tag, input logic s, input logic [31:0] addr,
                             input logic [2:0] f3, input logic [31:0] b0, input logic [31:0] b1,
                             input logic [31:0] exp_data, input logic exp_err,
                             input int exp_lat, input int exp_reads);
        int          nreads;
        logic        pend;
        logic        done;
        logic [31:0] base;
        logic [31:0] exp_a;
        base   = {addr[31:2], 2'b00};
        nreads = 0;
        pend   = 1'b0;
        done   = 1'b0;
        @(negedge clk);
        sel = s; req_valid = 1'b1; req_addr = addr; req_funct3 = f3;
        mem_req_ready = 1'b1; resp_ready = 1'b0; mem_rvalid = 1'b0;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            #1;
            if (cyc == 0) check({tag, ".req_ready"}, 64'(o_req_ready), 64'd1);
            pend = 1'b0;
            if (o_mem_req_valid) begin
                exp_a = base + 32'(4 * nreads);
                check({tag, ".mem_addr"}, 64'(o_mem_addr), 64'(exp_a));
                nreads++;
                pend = 1'b1;
            end
            if (o_resp_valid) begin
                done = 1'b1;
                check({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
                check({tag, ".data"}, 64'(o_resp_data), 64'(exp_data));
                check({tag, ".err"}, 64'(o_resp_err), 64'(exp_err));
                check({tag, ".reads"}, 64'(nreads), 64'(exp_reads));
                resp_ready = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            req_valid  = 1'b0;
            resp_ready = 1'b0;
            mem_rvalid = pend;
            mem_rdata  = (nreads == 1) ? b0 : b1;
        end
        if (!done) begin
            n_checks++;
            n_errors++;
            $error("FAIL %s.timeout observed=no_resp expected=resp_valid", tag);
        end
        mem_rvalid = 1'b0;
        #1;
        check({tag, ".idle_after"}, 64'(o_req_ready), 64'd1);
    endtask

    initial begin
        sel = 1'b0; req_valid = 1'b0; req_addr = 32'd0; req_funct3 = 3'd0;
        mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0; resp_ready = 1'b0;
        w_req_valid = 1'b0; w_req_addr = 32'd0; w_req_funct3 = 3'd0;
        w_mem_req_ready = 1'b0; w_mem_rvalid = 1'b0; w_mem_rdata = 64'd0; w_resp_ready = 1'b0;
        rst_n = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst.req_ready", 64'(o_req_ready), 64'd0);
        check("rst.mem_req_valid", 64'(o_mem_req_valid), 64'd0);
        check("rst.mem_addr", 64'(o_mem_addr), 64'd0);
        check("rst.resp_valid", 64'(o_resp_valid), 64'd0);
        check("rst.resp_data", 64'(o_resp_data), 64'd0);
        check("rst.resp_err", 64'(o_resp_err), 64'd0);
        check("rst.w_req_ready", 64'(if_w.req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst.req_ready_release", 64'(o_req_ready), 64'd1);

        // Main function on the 32-bit split-capable unit
        do_load32("lw_aligned", 1'b0, 32'h100, 3'b010, 32'h44332211, 32'h0, 32'h11223344, 1'b0, 3, 1);
        do_load32("lb_neg",     1'b0, 32'h103, 3'b000, 32'h80000000, 32'h0, 32'hFFFFFF80, 1'b0, 3, 1);
        do_load32("lbu",        1'b0, 32'h103, 3'b100, 32'h80000000, 32'h0, 32'h00000080, 1'b0, 3, 1);
        do_load32("lh_aligned", 1'b0, 32'h102, 3'b001, 32'h44332211, 32'h0, 32'h00003344, 1'b0, 3, 1);
        do_load32("lh_cross",   1'b0, 32'h103, 3'b001, 32'hAB000000, 32'h000000CD, 32'hFFFFABCD, 1'b0, 5, 2);
        do_load32("lhu_cross",  1'b0, 32'h103, 3'b101, 32'hAB000000, 32'h000000CD, 32'h0000ABCD, 1'b0, 5, 2);
        do_load32("lw_cross",   1'b0, 32'h102, 3'b010, 32'h44332211, 32'h88776655, 32'h33445566, 1'b0, 5, 2);
        do_load32("lw_wrap",    1'b0, 32'hFFFFFFFE, 3'b010, 32'h44332211, 32'h88776655, 32'h33445566, 1'b0, 5, 2);
        do_load32("ld_on32",    1'b0, 32'h100, 3'b011, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0);
        do_load32("f3_111",     1'b0, 32'h100, 3'b111, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0);

        // Misaligned accesses rejected when splitting is disabled
        do_load32("lw_misal_err", 1'b1, 32'h102, 3'b010, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0);
        do_load32("lh_misal_err", 1'b1, 32'h101, 3'b001, 32'h0, 32'h0, 32'h0, 1'b1, 1, 0);
        do_load32("lw_noerr_ok",  1'b1, 32'h100, 3'b010, 32'h44332211, 32'h0, 32'h11223344, 1'b0, 3, 1);

        // Backpressure on the 64-bit unit: ld at 0x8
        @(negedge clk);
        w_req_valid = 1'b1; w_req_addr = 32'h8; w_req_funct3 = 3'b011;
        w_mem_req_ready = 1'b0; w_resp_ready = 1'b0;
        #1;
        check("bp.accept_ready", 64'(if_w.req_ready), 64'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            w_req_valid = 1'b0;
            w_mem_req_ready = (k == 2);
            #1;
            check("bp.stall_valid", 64'(if_w.mem_req_valid), 64'd1);
            check("bp.stall_addr", 64'(if_w.mem_addr), 64'h8);
            check("bp.stall_req_ready", 64'(if_w.req_ready), 64'd0);
        end
        @(negedge clk);
        w_mem_req_ready = 1'b0; w_mem_rvalid = 1'b1; w_mem_rdata = 64'h0807060504030201;
        #1;
        check("bp.req_dropped", 64'(if_w.mem_req_valid), 64'd0);
        @(negedge clk);
        w_mem_rvalid = 1'b0; w_mem_rdata = 64'hDEADBEEFDEADBEEF;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp.resp_valid", 64'(if_w.resp_valid), 64'd1);
            check("bp.resp_data", if_w.resp_data, 64'h0102030405060708);
            check("bp.resp_err", 64'(if_w.resp_err), 64'd0);
            check("bp.resp_req_ready", 64'(if_w.req_ready), 64'd0);
            @(negedge clk);
        end
        w_resp_ready = 1'b1;
        #1;
        check("bp.handshake_data", if_w.resp_data, 64'h0102030405060708);
        @(negedge clk);
        w_resp_ready = 1'b0;
        #1;
        check("bp.done_valid", 64'(if_w.resp_valid), 64'd0);
        check("bp.done_ready", 64'(if_w.req_ready), 64'd1);

        // Reset while waiting for the second beat of a crossing lh
        @(negedge clk);
        sel = 1'b0; req_valid = 1'b1; req_addr = 32'h103; req_funct3 = 3'b001;
        mem_req_ready = 1'b1; resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'hAB000000;
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check("midrst.req1_addr", 64'(o_mem_addr), 64'h104);
        @(negedge clk);
        #1;
        check("midrst.in_wait1", 64'(o_mem_req_valid), 64'd0);
        rst_n = 1'b0;
        #1;
        check("midrst.req_ready", 64'(o_req_ready), 64'd0);
        check("midrst.mem_addr", 64'(o_mem_addr), 64'd0);
        check("midrst.resp_valid", 64'(o_resp_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h000000CD;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_rvalid = (k == 0);
            #1;
            check("midrst.no_resp", 64'(o_resp_valid), 64'd0);
            check("midrst.no_mem", 64'(o_mem_req_valid), 64'd0);
            check("midrst.idle", 64'(o_req_ready), 64'd1);
        end
        do_load32("lw_after_rst", 1'b0, 32'h200, 3'b010, 32'hDDCCBBAA, 32'h0, 32'hAABBCCDD, 1'b0, 3, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Absolute guard against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ld_align_unit.md
Name: ld_align_unit

Overview:
- Sequential load unit between the LSU request path and data memory.
- Accepts one load at a time: (byte address, funct3).
- Issues one or two word-aligned memory reads. Two reads are needed when the access crosses a word boundary.
- Extracts, merges, byte-orders and sign/zero-extends the data, then returns it over a valid/ready response port.
- Generalises the combinational load decoder to DATA_WIDTH 32/64, misaligned accesses, illegal-op reporting and handshakes.

Parameters:
- DATA_WIDTH, 32, width of the memory word and the result. Legal values are 32 and 64. BYTES = DATA_WIDTH/8.
- ADDR_WIDTH, 32, byte address width.
- MISALIGNED_EN, 1, selects misaligned handling. 1: split misaligned accesses into two reads. 0: report misaligned accesses as an error.

Ports:
- clk  in  1  clock. Single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  a load request is present.
- req_ready  out  1  unit accepts a request. Equals (state==IDLE) && rst_n.
- req_addr  in  ADDR_WIDTH  byte address.
- req_funct3  in  3  RISC-V load funct3.
- mem_req_valid  out  1  memory read request.
- mem_req_ready  in  1  memory accepts the request.
- mem_addr  out  ADDR_WIDTH  word-aligned read address. Low log2(BYTES) bits are always 0.
- mem_rvalid  in  1  read data valid. At most one read is outstanding.
- mem_rdata  in  DATA_WIDTH  read data. Byte lane k, i.e. bits [8k+7:8k], holds the byte at word address + k.
- resp_valid  out  1  result valid.
- resp_ready  in  1  consumer accepts the result.
- resp_data  out  DATA_WIDTH  extended load result.
- resp_err  out  1  illegal funct3, or misaligned access with MISALIGNED_EN=0.

Behaviour:
- Access size by funct3:
  - 000 lb, 100 lbu: 1 byte.
  - 001 lh, 101 lhu: 2 bytes.
  - 010 lw: 4 bytes.
  - 110 lwu, 011 ld: 4 and 8 bytes respectively. Legal only when DATA_WIDTH=64.
  - 111, and 011/110 when DATA_WIDTH=32: illegal.
- Address decomposition: off = addr[log2(BYTES)-1:0]; base = addr with off cleared.
- Crossing condition: cross = off + size > BYTES.
- Misaligned condition: off is not a multiple of size.
- Byte order: the result is big-endian. The byte at the lowest address becomes the most significant byte of the size-byte value.
  - Signed ops extend from bit 7 of the byte at the lowest address.
  - Unsigned ops (100/101/110) zero-extend.
- Merge: form the 2*BYTES-byte array {beat1, beat0}. Bytes off .. off+size-1 are taken in ascending address order.
- FSM states and transitions:
  - IDLE: req_ready=1.
    - On req_valid, register addr and funct3.
    - Illegal op → RESP with err=1.
    - Misaligned access and MISALIGNED_EN=0 → RESP with err=1.
    - Otherwise → REQ0.
  - REQ0: mem_req_valid=1, mem_addr=base. On mem_req_ready → WAIT0.
  - WAIT0: on mem_rvalid, store beat0. If cross → REQ1, else → RESP.
  - REQ1: mem_req_valid=1, mem_addr=base+BYTES (wraps modulo 2^ADDR_WIDTH). On mem_req_ready → WAIT1.
  - WAIT1: on mem_rvalid, store beat1 → RESP.
  - RESP: resp_valid=1. resp_data and resp_err are registered and held stable until resp_ready; then → IDLE.
- Error responses: resp_data=0 and no memory request is issued.
- Stall handling: mem_req_valid and mem_addr are held stable while mem_req_ready=0.
- mem_rvalid is ignored outside WAIT0 and WAIT1.
- Minimum latency, with mem_req_ready and mem_rvalid each on the first opportunity:
  - aligned: accept at cycle 0, resp_valid at cycle 3;
  - crossing: resp_valid at cycle 5;
  - error: resp_valid at cycle 1.
- Throughput: no new request is accepted until the response handshake completes, so the next accept is the cycle after it.
- Reset state: IDLE. mem_req_valid=0, mem_addr=0, resp_valid=0, resp_data=0, resp_err=0, req_ready=0 while rst_n is low.
- Reset mid-operation: the operation is abandoned with no response. Any late mem_rvalid arriving while in IDLE is ignored.

Test Plan:
- Aligned lw (DATA_WIDTH=32):
  - Stimulus: addr 0x100, mem_rdata 0x44332211.
  - Response: one read at 0x100; resp_data=0x11223344, err=0; resp_valid at cycle 3.
- Byte loads (DATA_WIDTH=32):
  - Stimulus: lb at 0x103 with lane3=0x80.
  - Response: 0xFFFFFF80. The same access as lbu returns 0x00000080.
- Crossing lh (DATA_WIDTH=32):
  - Stimulus: lh at 0x103; beat0 @0x100 has lane3=0xAB, beat1 @0x104 has lane0=0xCD.
  - Response: two reads; resp_data=0xFFFFABCD. The same access as lhu returns 0x0000ABCD.
- Errors (DATA_WIDTH=32):
  - Stimulus: lw at 0x102 with MISALIGNED_EN=0; also funct3=011.
  - Response: resp_err=1, resp_data=0, mem_req_valid never asserted, resp_valid at cycle 1.
- Backpressure (DATA_WIDTH=64):
  - Stimulus: ld at 0x8, mem_rdata=0x0807060504030201; mem_req_ready low 2 cycles; resp_ready low 3 cycles.
  - Response: mem_addr held at 0x8 while stalled; resp_data=0x0102030405060708 held stable; req_ready=0 until the handshake completes.
- Reset mid-op:
  - Stimulus: rst_n low while in WAIT1, then mem_rvalid pulses after release.
  - Response: all outputs return to reset values; no resp_valid; the next lw completes normally.
